// File: rtl/cnt_pkg.sv
// Shared types and constants for the modulo up/down counter stage.
// Repeat-timer defaults only matter when CNT_AUTO_REPEAT_EN is defined.
package cnt_pkg;

    typedef logic signed [2:0] step_t;

    localparam int REPEAT_DELAY_DEF  = 500;
    localparam int REPEAT_PERIOD_DEF = 100;

    function automatic int tmr_width(input int delay);
        return $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/btn_press_gen.sv
// Press detector for one active-low button: falling-edge detect plus,
// with CNT_AUTO_REPEAT_EN defined, a hold-to-repeat down-counter.
module btn_press_gen
    import cnt_pkg::*;
#(
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic btn_n_i,
    output logic press_o
);

    logic prev_q;
    logic edge_press;

    // History tracks the pin even while disabled, so enabling never fakes a press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn_n_i;
        end
    end

    assign edge_press = prev_q & ~btn_n_i;

`ifdef CNT_AUTO_REPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (tmr_width(TMAX) < 1) ? 1 : tmr_width(TMAX);

    logic [TW-1:0] tmr_q;
    logic          rpt;

    // Terminal count of 1 marks the cycle the synthetic press is issued; 0 is idle.
    assign rpt     = ~btn_n_i & (tmr_q == TW'(1));
    assign press_o = edge_press | rpt;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || btn_n_i) begin
            tmr_q <= '0;
        end else if (edge_press) begin
            tmr_q <= TW'(REPEAT_DELAY);
        end else if (rpt) begin
            tmr_q <= TW'(REPEAT_PERIOD);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
        end
    end
`else
    logic unused_en;
    assign unused_en = en_i;
    assign press_o   = edge_press;
`endif

endmodule

// File: rtl/cnt_mod_updown.sv
// Modulo up/down counter stage with runtime upper limit, load and carry/borrow
// pulses; button auto-repeat is enabled by defining CNT_AUTO_REPEAT_EN.
module cnt_mod_updown
    import cnt_pkg::*;
#(
    parameter int WIDTH         = 7,
    parameter int MIN_VAL       = 0,
    parameter int MAX_VAL       = 99,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic             inc_n,
    input  logic             dec_n,
    input  logic [WIDTH-1:0] lim_max,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             carry_o,
    output logic             borrow_o
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

    logic             inc_press;
    logic             dec_press;
    step_t            delta;
    logic [WIDTH-1:0] eff_max;
    logic [WIDTH-1:0] load_clip;
    logic [WIDTH:0]   span;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   wrapped;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;

    btn_press_gen #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_inc (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .btn_n_i(inc_n),
        .press_o(inc_press)
    );

    btn_press_gen #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_dec (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .btn_n_i(dec_n),
        .press_o(dec_press)
    );

    assign delta = step_t'({2'b00, tick}) + step_t'({2'b00, inc_press})
                 - step_t'({2'b00, dec_press});

    always_comb begin
        eff_max = lim_max;
        if (lim_max > MAX_W) begin
            eff_max = MAX_W;
        end
        if (eff_max < MIN_W) begin
            eff_max = MIN_W;
        end

        load_clip = load_val;
        if (load_val > eff_max) begin
            load_clip = eff_max;
        end else if (load_val < MIN_W) begin
            load_clip = MIN_W;
        end
    end

    // Wrap math is done one bit wider so max+2 cannot overflow before subtracting N.
    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        span     = {1'b0, eff_max} - MIN_X + ONE_X;
        sum      = {1'b0, cnt_q} + {{(WIDTH-1){1'b0}}, delta[1:0]};
        wrapped  = sum - span;

        if (load) begin
            cnt_d = load_clip;
        end else if (cnt_q > eff_max) begin
            cnt_d = eff_max;
        end else if (en) begin
            case (delta)
                3'b001, 3'b010: begin
                    if (sum > {1'b0, eff_max}) begin
                        if (wrapped > {1'b0, eff_max}) begin
                            wrapped = MIN_X;
                        end
                        cnt_d   = wrapped[WIDTH-1:0];
                        carry_d = 1'b1;
                    end else begin
                        cnt_d = sum[WIDTH-1:0];
                    end
                end
                3'b111: begin
                    if (cnt_q == MIN_W) begin
                        cnt_d    = eff_max;
                        borrow_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= MIN_W;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign cnt      = cnt_q;
    assign carry_o  = carry_q;
    assign borrow_o = borrow_q;

endmodule
